// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic feeder: default operand width, state
// encoding and the counter-width helper.
package systolic_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int BEAT_W_MIN = 6;

  typedef enum logic [1:0] {
    FS_LOAD   = 2'd0,
    FS_STREAM = 2'd1,
    FS_FLUSH  = 2'd2,
    FS_DONE   = 2'd3
  } feeder_state_e;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/feeder_skew_sel.sv
// Diagonal-wavefront element select for one edge lane. Row lanes pick A[lane][t-lane],
// column lanes pick B[t-lane][lane]; anything off the valid diagonal is zero.
module feeder_skew_sel
  import systolic_pkg::*;
#(
  parameter int DIM      = 2,
  parameter int DW       = DW_DEFAULT,
  parameter int TW       = 2,
  parameter bit ROW_MODE = 1'b1
) (
  input  logic [DIM*DIM*DW-1:0] mat,
  input  logic [TW-1:0]         lane,
  input  logic [TW-1:0]         t,
  output logic [DW-1:0]         elem
);

  int k;
  int idx;

  always_comb begin
    elem = '0;
    idx  = 0;
    // Signed difference so lanes not yet reached by the wavefront go negative.
    k    = int'(t) - int'(lane);
    if (k >= 0 && k < DIM) begin
      idx  = ROW_MODE ? (int'(lane) * DIM + k) : (k * DIM + int'(lane));
      elem = mat[idx*DW +: DW];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Skew feeder for an N x N systolic tile: loads A then B row-major, then streams
// both as diagonal wavefronts with EN and a DONE pulse. Optional perf counters
// are built when SYSTOLIC_FEEDER_PERF_EN is defined.
//
// Load handshake: a beat transfers on any rising edge where LD_VALID && LD_READY;
// LD_READY is high exactly in LOAD and LD_VALID is ignored in every other state.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DIM = 2,
  parameter int DW  = DW_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [DW-1:0]     LD_DATA,
  output logic              EN,
  output logic [DIM*DW-1:0] N_RX,
  output logic [DIM*DW-1:0] N_CX,
  output logic              BUSY,
  output logic              DONE,
  output logic [1:0]        fsm_state
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [31:0]       JOB_CNT,
  output logic [31:0]       BUSY_CYC
`endif
);

  localparam logic [1:0] ST_LOAD   = FS_LOAD;
  localparam logic [1:0] ST_STREAM = FS_STREAM;
  localparam logic [1:0] ST_FLUSH  = FS_FLUSH;
  localparam logic [1:0] ST_DONE   = FS_DONE;

  localparam int NN = DIM * DIM;
  localparam int BW = (cnt_w(2 * NN) > BEAT_W_MIN) ? cnt_w(2 * NN) : BEAT_W_MIN;
  localparam int TW = cnt_w(2 * DIM - 1);
  localparam int FW = cnt_w(DIM - 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(2 * NN - 1);
  localparam logic [BW-1:0] B_FIRST   = BW'(NN);
  localparam logic [TW-1:0] T_LAST    = TW'(2 * DIM - 2);
  localparam logic [FW-1:0] F_LAST    = FW'(DIM - 2);

  logic [1:0]           state, state_nxt;
  logic [BW-1:0]        beat, beat_nxt;
  logic [TW-1:0]        t, t_nxt;
  logic [FW-1:0]        f, f_nxt;
  logic [NN*DW-1:0]     a_buf, a_nxt;
  logic [NN*DW-1:0]     b_buf, b_nxt;
  logic [DW-1:0]        rx_sel [DIM];
  logic [DW-1:0]        cx_sel [DIM];
  logic [DIM*DW-1:0]    rx_flat, cx_flat;
  logic                 active_q, done_q;
  logic [DIM*DW-1:0]    rx_q, cx_q;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    t_nxt     = t;
    f_nxt     = f;
    a_nxt     = a_buf;
    b_nxt     = b_buf;
    case (state)
      ST_LOAD: begin
        if (LD_VALID) begin
          if (beat < B_FIRST) a_nxt[int'(beat)*DW +: DW] = LD_DATA;
          else                b_nxt[(int'(beat) - NN)*DW +: DW] = LD_DATA;
          if (beat == LAST_BEAT) begin
            state_nxt = ST_STREAM;
            t_nxt     = '0;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (t == T_LAST) begin
          state_nxt = (DIM > 1) ? ST_FLUSH : ST_DONE;
          f_nxt     = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (f == F_LAST) state_nxt = ST_DONE;
        else             f_nxt     = f + 1'b1;
      end
      ST_DONE: begin
        state_nxt = ST_LOAD;
        beat_nxt  = '0;
        t_nxt     = '0;
        f_nxt     = '0;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Lanes look at the post-edge buffer and step so registered outputs line up
  // with the state they describe, including the step that follows the last beat.
  for (genvar g = 0; g < DIM; g++) begin : g_lane
    feeder_skew_sel #(.DIM(DIM), .DW(DW), .TW(TW), .ROW_MODE(1'b1)) u_row (
      .mat  (a_nxt),
      .lane (TW'(g)),
      .t    (t_nxt),
      .elem (rx_sel[g])
    );
    feeder_skew_sel #(.DIM(DIM), .DW(DW), .TW(TW), .ROW_MODE(1'b0)) u_col (
      .mat  (b_nxt),
      .lane (TW'(g)),
      .t    (t_nxt),
      .elem (cx_sel[g])
    );
  end

  always_comb begin
    rx_flat = '0;
    cx_flat = '0;
    for (int i = 0; i < DIM; i++) begin
      rx_flat[i*DW +: DW] = rx_sel[i];
      cx_flat[i*DW +: DW] = cx_sel[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_LOAD;
      beat     <= '0;
      t        <= '0;
      f        <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      rx_q     <= '0;
      cx_q     <= '0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      t        <= t_nxt;
      f        <= f_nxt;
      active_q <= (state_nxt == ST_STREAM) || (state_nxt == ST_FLUSH);
      done_q   <= (state_nxt == ST_DONE);
      rx_q     <= (state_nxt == ST_STREAM) ? rx_flat : '0;
      cx_q     <= (state_nxt == ST_STREAM) ? cx_flat : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_buf <= a_nxt;
      b_buf <= b_nxt;
    end
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      JOB_CNT  <= '0;
      BUSY_CYC <= '0;
    end else begin
      JOB_CNT  <= JOB_CNT + {31'd0, done_q};
      BUSY_CYC <= BUSY_CYC + {31'd0, active_q};
    end
  end
`endif

  assign LD_READY  = (state == ST_LOAD);
  assign EN        = active_q;
  assign BUSY      = active_q;
  assign DONE      = done_q;
  assign N_RX      = rx_q;
  assign N_CX      = cx_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (2x2, 32-bit); perf counters are checked
// when SYSTOLIC_FEEDER_PERF_EN is defined.
module tb_systolic_feeder;

  localparam int DIM = 2;
  localparam int DW  = 32;

  logic              CLK;
  logic              RST;
  logic              LD_VALID;
  logic              LD_READY;
  logic [DW-1:0]     LD_DATA;
  logic              EN;
  logic [DIM*DW-1:0] N_RX;
  logic [DIM*DW-1:0] N_CX;
  logic              BUSY;
  logic              DONE;
  logic [1:0]        fsm_state;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0]       JOB_CNT;
  logic [31:0]       BUSY_CYC;
`endif

  int total;
  int bad;

  systolic_feeder #(.DIM(DIM), .DW(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LD_VALID  (LD_VALID),
    .LD_READY  (LD_READY),
    .LD_DATA   (LD_DATA),
    .EN        (EN),
    .N_RX      (N_RX),
    .N_CX      (N_CX),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .fsm_state (fsm_state)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    .JOB_CNT   (JOB_CNT),
    .BUSY_CYC  (BUSY_CYC)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".en"},    64'(EN),        64'd0);
    chk({tag, ".busy"},  64'(BUSY),      64'd0);
    chk({tag, ".done"},  64'(DONE),      64'd0);
    chk({tag, ".rx"},    N_RX,           64'd0);
    chk({tag, ".cx"},    N_CX,           64'd0);
    chk({tag, ".ready"}, 64'(LD_READY),  64'd1);
    chk({tag, ".st"},    64'(fsm_state), 64'd0);
  endtask

  task automatic chk_step(input string tag, input logic [63:0] rx, input logic [63:0] cx);
    chk({tag, ".rx"},    N_RX,          rx);
    chk({tag, ".cx"},    N_CX,          cx);
    chk({tag, ".en"},    64'(EN),       64'd1);
    chk({tag, ".busy"},  64'(BUSY),     64'd1);
    chk({tag, ".done"},  64'(DONE),     64'd0);
    chk({tag, ".ready"}, 64'(LD_READY), 64'd0);
  endtask

  // driver: 8 beats with data base..base+7; stall inserts an idle cycle between beats
  task automatic load_job(input int base, input bit stall, input bit hold99);
    for (int k = 0; k < 2 * DIM * DIM; k++) begin
      LD_VALID = 1'b1;
      LD_DATA  = DW'(base + k);
      chk($sformatf("load%0d.ready", k), 64'(LD_READY), 64'd1);
      step();
      if (stall && k < 2 * DIM * DIM - 1) begin
        LD_VALID = 1'b0;
        LD_DATA  = 32'hdead_beef;
        step();
        chk($sformatf("stall%0d.en", k), 64'(EN), 64'd0);
        chk($sformatf("stall%0d.ready", k), 64'(LD_READY), 64'd1);
      end
    end
    LD_VALID = hold99;
    LD_DATA  = hold99 ? 32'd99 : 32'd0;
  endtask

  // expected outputs of one job, starting at step 0 already on the outputs
  task automatic expect_job(input string tag,
                            input logic [63:0] r0, input logic [63:0] c0,
                            input logic [63:0] r1, input logic [63:0] c1,
                            input logic [63:0] r2, input logic [63:0] c2);
    chk_step({tag, ".s0"}, r0, c0);
    chk({tag, ".s0.st"}, 64'(fsm_state), 64'd1);
    step();
    chk_step({tag, ".s1"}, r1, c1);
    step();
    chk_step({tag, ".s2"}, r2, c2);
    step();
    chk_step({tag, ".fl"}, 64'd0, 64'd0);
    chk({tag, ".fl.st"}, 64'(fsm_state), 64'd2);
    step();
    chk({tag, ".dn.done"},  64'(DONE),      64'd1);
    chk({tag, ".dn.en"},    64'(EN),        64'd0);
    chk({tag, ".dn.busy"},  64'(BUSY),      64'd0);
    chk({tag, ".dn.rx"},    N_RX,           64'd0);
    chk({tag, ".dn.cx"},    N_CX,           64'd0);
    chk({tag, ".dn.ready"}, 64'(LD_READY),  64'd0);
    chk({tag, ".dn.st"},    64'(fsm_state), 64'd3);
    step();
    chk({tag, ".post.done"},  64'(DONE),     64'd0);
    chk({tag, ".post.en"},    64'(EN),       64'd0);
    chk({tag, ".post.ready"}, 64'(LD_READY), 64'd1);
  endtask

  // A=[[1,2],[3,4]] B=[[5,6],[7,8]]; slice i of each edge bus = bits [i*32 +: 32]
  localparam logic [63:0] R0 = 64'h00000000_00000001;
  localparam logic [63:0] C0 = 64'h00000000_00000005;
  localparam logic [63:0] R1 = 64'h00000003_00000002;
  localparam logic [63:0] C1 = 64'h00000006_00000007;
  localparam logic [63:0] R2 = 64'h00000004_00000000;
  localparam logic [63:0] C2 = 64'h00000008_00000000;

  initial begin
    total    = 0;
    bad      = 0;
    RST      = 1'b1;
    LD_VALID = 1'b0;
    LD_DATA  = '0;

    // reset
    step();
    step();
    chk_idle("rst_hold");
    RST = 1'b0;
    step();
    chk_idle("rst_rel");

    // basic 2x2 job
    load_job(1, 1'b0, 1'b0);
    expect_job("basic", R0, C0, R1, C1, R2, C2);

    // stalled load, valid toggling every cycle
    load_job(1, 1'b1, 1'b0);
    expect_job("stall", R0, C0, R1, C1, R2, C2);

    // LD_VALID held with 99 through STREAM/FLUSH/DONE, then a new job
    load_job(1, 1'b0, 1'b1);
    expect_job("ign99", R0, C0, R1, C1, R2, C2);
    load_job(9, 1'b0, 1'b0);
    // A=[[9,10],[11,12]] B=[[13,14],[15,16]]
    expect_job("next",
               64'h00000000_00000009, 64'h00000000_0000000d,
               64'h0000000b_0000000a, 64'h0000000e_0000000f,
               64'h0000000c_00000000, 64'h00000010_00000000);

    // reset after three beats discards the partial load
    for (int k = 0; k < 3; k++) begin
      LD_VALID = 1'b1;
      LD_DATA  = 32'd50 + 32'(k);
      step();
    end
    RST      = 1'b1;
    LD_VALID = 1'b0;
    step();
    RST = 1'b0;
    chk_idle("rst_load");

    // reset at stream step 1 aborts without DONE
    load_job(1, 1'b0, 1'b0);
    chk_step("abort.s0", R0, C0);
    step();
    chk_step("abort.s1", R1, C1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk_idle("abort.rst");
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("abort.nodone%0d", k), 64'(DONE), 64'd0);
      chk($sformatf("abort.noen%0d", k), 64'(EN), 64'd0);
    end
    load_job(1, 1'b0, 1'b0);
    expect_job("fresh", R0, C0, R1, C1, R2, C2);

`ifdef SYSTOLIC_FEEDER_PERF_EN
    // back-to-back jobs from a clean reset
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("perf.rst.jobs", 64'(JOB_CNT), 64'd0);
    chk("perf.rst.busy", 64'(BUSY_CYC), 64'd0);
    load_job(1, 1'b0, 1'b0);
    expect_job("perf1", R0, C0, R1, C1, R2, C2);
    load_job(1, 1'b0, 1'b0);
    expect_job("perf2", R0, C0, R1, C1, R2, C2);
    chk("perf.jobs", 64'(JOB_CNT), 64'd2);
    chk("perf.busy", 64'(BUSY_CYC), 64'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
